// File: rtl/logic_issue_ctrl.sv
// Issue controller that feeds one uop to the logical unit and queues results.
// Define LOGIC_ISSUE_ILLEGAL_CHK_EN to retire illegal codes directly to writeback.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CTRL_AND
`define CTRL_AND  3'b000
`define CTRL_OR   3'b001
`define CTRL_XOR  3'b010
`define CTRL_ANDI 3'b100
`define CTRL_ORI  3'b101
`define CTRL_XORI 3'b110
`endif

module logic_issue_ctrl #(
    parameter int TAG_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_logic_type,
    input  logic [`DATA_WIDTH-1:0] in_src1,
    input  logic [`DATA_WIDTH-1:0] in_src2,
    input  logic [20:0]            in_imm,
    input  logic [TAG_W-1:0]       in_rd,
    output logic                   lu_uop_valid,
    output logic [2:0]             lu_logic_type,
    output logic [`DATA_WIDTH-1:0] lu_src1,
    output logic [`DATA_WIDTH-1:0] lu_src2,
    output logic [20:0]            lu_immediate,
    input  logic [`DATA_WIDTH-1:0] lu_result,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [TAG_W-1:0]       wb_rd,
    output logic [`DATA_WIDTH-1:0] wb_value,
    output logic                   wb_illegal
);

    localparam int DW = `DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXEC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0]       typ;
        logic [DW-1:0]    src1;
        logic [DW-1:0]    src2;
        logic [20:0]      imm;
        logic [TAG_W-1:0] rd;
    } hold_t;

    state_t           state_q, state_d;
    hold_t            hold_q, hold_d;
    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, rd_ptr_q;
    logic [TAG_W-1:0] fifo_rd_q  [2];
    logic [DW-1:0]    fifo_val_q [2];

    logic             push, pop, go_exec, ill_push, wr_en;
    logic [TAG_W-1:0] wr_rd;
    logic [DW-1:0]    wr_val;

    assign push = !reset && (state_q == CAPTURE)
               && ((count_q != 2'd2) || wb_ready);
    assign pop  = !reset && (count_q != 2'd0) && wb_ready;

`ifdef LOGIC_ISSUE_ILLEGAL_CHK_EN
    logic legal;
    logic fifo_ill_q [2];

    assign legal = (in_logic_type == `CTRL_AND)
                || (in_logic_type == `CTRL_OR)
                || (in_logic_type == `CTRL_XOR)
                || (in_logic_type == `CTRL_ANDI)
                || (in_logic_type == `CTRL_ORI)
                || (in_logic_type == `CTRL_XORI);
    // Illegal uops retire on the accept edge, so they need a free slot now.
    assign in_ready = !reset
        && (((state_q == IDLE) && (legal || (count_q != 2'd2)))
            || (push && legal));
    assign go_exec  = in_valid && in_ready && legal;
    assign ill_push = in_valid && in_ready && !legal;
`else
    assign in_ready = !reset && ((state_q == IDLE) || push);
    assign go_exec  = in_valid && in_ready;
    assign ill_push = 1'b0;
`endif

    assign wr_en  = push || ill_push;
    assign wr_rd  = push ? hold_q.rd : in_rd;
    assign wr_val = push ? lu_result : '0;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        unique case (state_q)
            IDLE:    if (go_exec) state_d = EXEC;
            EXEC:    state_d = CAPTURE;
            CAPTURE: if (push) state_d = go_exec ? EXEC : IDLE;
            default: state_d = IDLE;
        endcase
        if (go_exec) begin
            hold_d.typ  = in_logic_type;
            hold_d.src1 = in_src1;
            hold_d.src2 = in_src2;
            hold_d.imm  = in_imm;
            hold_d.rd   = in_rd;
        end else if (push) begin
            hold_d = '0;
        end
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            count_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
            if (wr_en) begin
                fifo_rd_q[wr_ptr_q]  <= wr_rd;
                fifo_val_q[wr_ptr_q] <= wr_val;
`ifdef LOGIC_ISSUE_ILLEGAL_CHK_EN
                fifo_ill_q[wr_ptr_q] <= ill_push;
`endif
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // hold_q is cleared whenever the FSM returns to IDLE.
    assign lu_uop_valid  = !reset && (state_q == CAPTURE);
    assign lu_logic_type = reset ? '0 : hold_q.typ;
    assign lu_src1       = reset ? '0 : hold_q.src1;
    assign lu_src2       = reset ? '0 : hold_q.src2;
    assign lu_immediate  = reset ? '0 : hold_q.imm;

    assign wb_valid = !reset && (count_q != 2'd0);
    assign wb_rd    = wb_valid ? fifo_rd_q[rd_ptr_q] : '0;
    assign wb_value = wb_valid ? fifo_val_q[rd_ptr_q] : '0;
`ifdef LOGIC_ISSUE_ILLEGAL_CHK_EN
    assign wb_illegal = wb_valid ? fifo_ill_q[rd_ptr_q] : 1'b0;
`else
    assign wb_illegal = 1'b0;
`endif

endmodule

// File: doc/logic_issue_ctrl.md
LOGIC_ISSUE_CTRL -- requirements
Module: logic_issue_ctrl

Interface
REQ-001 SHALL have parameter TAG_W, default 5, meaning destination-register tag width; data width SHALL be `DATA_WIDTH; logic codes SHALL be the `CTRL_* encodings.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  decoded logic uop offered.
REQ-005 SHALL have port in_ready  output  1  uop accepted when in_valid&in_ready at a rising edge.
REQ-006 SHALL have port in_logic_type  input  3  `CTRL_* code; MSB selects immediate.
REQ-007 SHALL have ports in_src1, in_src2  input  `DATA_WIDTH  operands.
REQ-008 SHALL have port in_imm  input  21  immediate.
REQ-009 SHALL have port in_rd  input  TAG_W  destination tag.
REQ-010 SHALL have port lu_uop_valid  output  1  drives logical unit uop_valid_in.
REQ-011 SHALL have ports lu_logic_type (3), lu_src1, lu_src2 (`DATA_WIDTH), lu_immediate (21)  output  held uop fields to logical unit.
REQ-012 SHALL have port lu_result  input  `DATA_WIDTH  logical unit logical_value.
REQ-013 SHALL have port wb_valid  output  1  writeback entry available.
REQ-014 SHALL have port wb_ready  input  1  entry popped when wb_valid&wb_ready at an edge.
REQ-015 SHALL have ports wb_rd (TAG_W), wb_value (`DATA_WIDTH), wb_illegal (1)  output  head entry fields.

Function
REQ-016 SHALL implement FSM IDLE, EXEC, CAPTURE, plus a 2-entry writeback FIFO {rd, value, illegal} with 2-bit count.
REQ-017 SHALL assert in_ready in IDLE, or in CAPTURE when push occurs that cycle; never in EXEC.
REQ-018 On accept, SHALL register in_* fields into a hold register and go to EXEC.
REQ-019 In EXEC and CAPTURE, lu_logic_type/lu_src1/lu_src2/lu_immediate SHALL equal the hold register, stable across both states; in IDLE they SHALL be zero.
REQ-020 EXEC SHALL last exactly one cycle, then go to CAPTURE.
REQ-021 lu_uop_valid SHALL be 1 only in CAPTURE.
REQ-022 push SHALL be CAPTURE && (count<2 || wb_ready); on push, {hold rd, lu_result, 0} is written to the FIFO tail.
REQ-023 CAPTURE SHALL hold, with lu_* outputs unchanged, while push is 0 (FIFO full, no pop).
REQ-024 On push, next state SHALL be EXEC if a new uop is accepted that same edge, else IDLE.
REQ-025 Latency SHALL be 2 edges from accept to FIFO write; wb_valid is visible after the next edge; throughput is one uop per 2 cycles.
REQ-026 Simultaneous push and pop SHALL leave count unchanged, and the FIFO SHALL preserve order.
REQ-027 wb_valid SHALL equal count!=0; wb_* SHALL show the head entry, and all wb_* fields SHALL be zero when empty.

Reset
REQ-028 reset SHALL force IDLE, count=0, FIFO pointers 0, hold register 0, and drop any in-flight uop.
REQ-029 During and immediately after reset, in_ready, lu_uop_valid, and wb_valid SHALL be 0, and lu_* and wb_* fields SHALL be 0.
REQ-030 reset asserted in EXEC or CAPTURE SHALL discard the uop with no FIFO write.

Configuration
REQ-031 With LOGIC_ISSUE_ILLEGAL_CHK_EN defined, an accepted uop whose code is not one of the six legal AND/OR/XOR/ANDI/ORI/XORI codes SHALL skip EXEC and CAPTURE.
REQ-032 Such an illegal uop SHALL push {rd, 0, 1} on the accept edge if count<2 (else in_ready=0 for it), and SHALL never raise lu_uop_valid.
REQ-033 Without LOGIC_ISSUE_ILLEGAL_CHK_EN, every code SHALL go through EXEC and CAPTURE, and wb_illegal SHALL be tied 0.

Verification
REQ-034 SHALL check: AND src1=0xF0F0F0F0, src2=0x0FF00FF0, rd=3, wb_ready=1 -> wb_value=0x00F000F0, wb_rd=3, wb_valid exactly 3 edges after accept.
REQ-035 SHALL check: XORI src1=0x0000FFFF, imm=0x1F00FF -> wb_value=0x001FFF00; lu_src2 is unchanged across EXEC and CAPTURE.
REQ-036 SHALL check: wb_ready=0 with 3 back-to-back ORs -> two entries stored, FSM stays in CAPTURE with in_ready=0; raising wb_ready drains all 3 in order.
REQ-037 SHALL check: reset pulsed in EXEC -> next cycle IDLE, wb_valid=0, and no entry appears.
REQ-038 SHALL check: with LOGIC_ISSUE_ILLEGAL_CHK_EN, illegal code, rd=7 -> wb entry {7, 0, illegal=1} after 1 edge, with lu_uop_valid never 1.
REQ-039 SHALL check: continuous valid uops with wb_ready=1 -> one accept every 2 cycles and FIFO count never exceeds 1.
